// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states, special IDs/vectors.
// Optional build macro used by the controller: INTC_SYNC_EN (2-flop input synchronisers).
package intc_pkg;

    localparam logic [1:0] OFF_MASK = 2'd0;
    localparam logic [1:0] OFF_MODE = 2'd1;
    localparam logic [1:0] OFF_PEND = 2'd2;
    localparam logic [1:0] OFF_STAT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intc_state_t;

    localparam logic [3:0]  ID_NMI       = 4'hE;
    localparam logic [3:0]  ID_NONE      = 4'hF;
    localparam logic [15:0] SPURIOUS_VEC = 16'hFFFE;

    // One-hot byte for a source id; ids 8 and above map to no bit.
    function automatic logic [7:0] idOneHot(input logic [3:0] id);
        return 8'd1 << id;
    endfunction

endpackage

// File: rtl/intc_priority_encoder.sv
// Fixed-priority encoder: the lowest-index eligible source wins.
module intc_priority_encoder
    import intc_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] eligible,
    output logic               any,
    output logic [3:0]         id
);

    always_comb begin
        any = 1'b0;
        id  = ID_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                any = 1'b1;
                id  = 4'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller for the 6502 core: maskable IRQ sources plus NMI, memory-mapped control.
// Build option: define INTC_SYNC_EN to add 2-flop synchronisers on irq_src and nmi_src.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter logic [15:0] BASE_ADDR = 16'hD000,
    parameter logic [15:0] VEC_BASE  = 16'hFFE0,
    parameter logic [15:0] NMI_VEC   = 16'hFFFA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               nmi_src,
    input  logic [15:0]        address,
    input  logic [7:0]         data_write,
    input  logic               read_write,
    output logic               reg_hit,
    output logic [7:0]         reg_data,
    output logic               irq_n,
    output logic               nmi_n,
    input  logic               int_ack,
    output logic [15:0]        vector,
    output logic [3:0]         active_id
);

    localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

    logic [NUM_SRC-1:0] w_irqSmp;
    logic               w_nmiSmp;

`ifdef INTC_SYNC_EN
    logic [NUM_SRC-1:0] r_irqMeta, r_irqSync;
    logic               r_nmiMeta, r_nmiSync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irqMeta <= '0;
            r_irqSync <= '0;
            r_nmiMeta <= 1'b0;
            r_nmiSync <= 1'b0;
        end else begin
            r_irqMeta <= irq_src;
            r_irqSync <= r_irqMeta;
            r_nmiMeta <= nmi_src;
            r_nmiSync <= r_nmiMeta;
        end
    end

    assign w_irqSmp = r_irqSync;
    assign w_nmiSmp = r_nmiSync;
`else
    assign w_irqSmp = irq_src;
    assign w_nmiSmp = nmi_src;
`endif

    logic [7:0]  r_mask, r_mode, r_pend, r_irqPrev;
    logic        r_nmiPrev, r_nmiPend;
    intc_state_t r_state;
    logic        r_irqN;
    logic [15:0] r_vector;
    logic [3:0]  r_activeId;

    logic [15:0] w_offset;
    logic [1:0]  w_regSel;
    logic        w_wrEn, w_eoi;
    logic [7:0]  w_w1c, w_smp8, w_rise, w_elig, w_ackClr, w_pendNext;
    logic        w_any, w_nmiRise, w_nmiAck, w_irqAccept;
    logic [3:0]  w_winId;

    // Window decode works for any BASE_ADDR, aligned or not.
    assign w_offset = address - BASE_ADDR;
    assign reg_hit  = (w_offset < 16'd4);
    assign w_regSel = w_offset[1:0];
    assign w_wrEn   = reg_hit & ~read_write;
    assign w_eoi    = w_wrEn && (w_regSel == OFF_STAT);
    assign w_w1c    = (w_wrEn && (w_regSel == OFF_PEND)) ? (data_write & SRC_MASK) : 8'h00;

    assign w_smp8    = 8'(w_irqSmp);
    assign w_rise    = w_smp8 & ~r_irqPrev;
    assign w_elig    = r_pend & r_mask;
    assign w_nmiRise = w_nmiSmp & ~r_nmiPrev;
    assign w_nmiAck  = int_ack & r_nmiPend;

    intc_priority_encoder #(.NUM_SRC(NUM_SRC)) u_prio (
        .eligible (w_elig[NUM_SRC-1:0]),
        .any      (w_any),
        .id       (w_winId)
    );

    assign w_irqAccept = int_ack & ~r_nmiPend & (r_state == ST_REQ) & w_any;
    assign w_ackClr    = w_irqAccept ? (idOneHot(w_winId) & r_mode) : 8'h00;

    // Edge bits: a fresh edge beats both W1C and ack-clear; level bits mirror the sampled input.
    assign w_pendNext = (r_mode & ((r_pend & ~w_w1c & ~w_ackClr) | w_rise)) |
                        (~r_mode & w_smp8);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask    <= 8'h00;
            r_mode    <= 8'h00;
            r_pend    <= 8'h00;
            r_irqPrev <= 8'h00;
            r_nmiPrev <= 1'b0;
            r_nmiPend <= 1'b0;
        end else begin
            if (w_wrEn && (w_regSel == OFF_MASK)) r_mask <= data_write & SRC_MASK;
            if (w_wrEn && (w_regSel == OFF_MODE)) r_mode <= data_write & SRC_MASK;
            r_pend    <= w_pendNext;
            r_irqPrev <= w_smp8;
            r_nmiPrev <= w_nmiSmp;
            r_nmiPend <= w_nmiRise | (r_nmiPend & ~w_nmiAck);
        end
    end

    // An NMI acknowledge takes the whole ack cycle and leaves the IRQ state machine untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_irqN     <= 1'b1;
            r_vector   <= SPURIOUS_VEC;
            r_activeId <= ID_NONE;
        end else if (w_nmiAck) begin
            r_vector   <= NMI_VEC;
            r_activeId <= ID_NMI;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_REQ;
                        r_irqN  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        r_irqN <= 1'b1;
                        if (w_any) begin
                            r_activeId <= w_winId;
                            r_vector   <= VEC_BASE + {11'd0, w_winId, 1'b0};
                            r_state    <= ST_SERVICE;
                        end else begin
                            r_activeId <= ID_NONE;
                            r_vector   <= SPURIOUS_VEC;
                            r_state    <= ST_IDLE;
                        end
                    end else if (!w_any) begin
                        r_irqN  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (w_eoi) begin
                        r_activeId <= ID_NONE;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_irqN  <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        reg_data = 8'h00;
        if (reg_hit) begin
            case (w_regSel)
                OFF_MASK: reg_data = r_mask;
                OFF_MODE: reg_data = r_mode;
                OFF_PEND: reg_data = r_pend;
                OFF_STAT: reg_data = {r_nmiPend, 3'b000, r_activeId};
                default:  reg_data = 8'h00;
            endcase
        end
    end

    assign irq_n     = r_irqN;
    assign nmi_n     = ~r_nmiPend;
    assign vector    = r_vector;
    assign active_id = r_activeId;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Parametrised interrupt controller for the 6502 core. It takes NUM_SRC maskable sources plus one NMI source and drives the core's active-low irq_n/nmi_n lines. The core acknowledges a request with a one-cycle int_ack pulse; the controller then returns a prioritised 16-bit vector and holds the accepted source until end-of-interrupt (EOI). Control/status registers are memory-mapped on the core's address/data_write/read_write bus.

Parameters:
NUM_SRC, 8, number of maskable sources; legal range 1..8, one bit per source in each byte register
BASE_ADDR, 16'hD000, base of the 4-byte register window
VEC_BASE, 16'hFFE0, IRQ vector table base; source n vectors to VEC_BASE + 2*n
NMI_VEC, 16'hFFFA, NMI vector

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
irq_src  input  NUM_SRC  maskable interrupt sources, active-high
nmi_src  input  1  NMI source; rising edge triggers
address  input  16  core address bus
data_write  input  8  core write data
read_write  input  1  1 = read, 0 = write (core convention)
reg_hit  output  1  address is inside the register window (combinational)
reg_data  output  8  register read data (combinational; 0 when not hit)
irq_n  output  1  active-low IRQ to core
nmi_n  output  1  active-low NMI to core
int_ack  input  1  one-cycle acknowledge from the control unit
vector  output  16  vector for the acknowledged interrupt, valid from the edge after int_ack until the next int_ack
active_id  output  4  accepted source: 0..7 = IRQ n, 4'hE = NMI, 4'hF = none/spurious

Behaviour:
- Reset (rst low, async) clears everything: MASK=0, MODE=0, PENDING=0, nmi_pend=0, edge history=0, state=IDLE, irq_n=1, nmi_n=1, vector=16'hFFFE, active_id=4'hF.
- Registers, at offsets from BASE_ADDR:
  - +0 MASK (RW): 1 = source enabled.
  - +1 MODE (RW): 1 = edge-triggered, 0 = level.
  - +2 PENDING (R; write-1-to-clear, edge bits only).
  - +3 STATUS: read returns {nmi_pend, 3'b0, active_id}; a write of any value is EOI.
  - Writes take effect on the clk edge where read_write=0 and reg_hit=1. Register bits at or above NUM_SRC read as 0.
- Pending bits:
  - Edge bit n is set on the edge where src_n & ~src_n_prev is seen.
  - Level bit n equals the current sampled level.
  - Set and W1C in the same cycle: set wins.
- Eligible = PENDING & MASK. Priority: lowest index wins.
- FSM states: IDLE, REQ, SERVICE. irq_n = ~(state==REQ), registered.
  - IDLE -> REQ on the edge where eligible != 0.
  - REQ + int_ack, eligible != 0:
    - latch winner id into active_id;
    - vector <= VEC_BASE + {id, 1'b0};
    - clear the winner's pending bit if it is edge mode;
    - go to SERVICE.
  - REQ + int_ack, eligible == 0 (source masked or withdrawn): spurious. active_id=4'hF, vector=16'hFFFE, go to IDLE.
  - REQ with eligible dropping to 0 and no ack: go to IDLE (irq_n deasserts).
  - SERVICE -> IDLE on an EOI write; active_id <= 4'hF.
  - New sources pend during SERVICE but are not requested (no nesting).
- NMI:
  - A rising edge of nmi_src sets nmi_pend; nmi_n = ~nmi_pend.
  - int_ack while nmi_pend=1 services the NMI first, in any state: vector=NMI_VEC, active_id=4'hE, nmi_pend cleared, FSM state unchanged.
  - A new NMI edge in the same cycle as the ack re-sets nmi_pend.
- int_ack with no NMI pending and state != REQ: ignored.
- Latency, INTC_SYNC_EN defined: a source edge first sampled at edge E0 sets pending at E2 and drives irq_n low after E3.
- Reset mid-operation aborts immediately to reset values; no ack or EOI is needed afterwards.

Optional Feature:
INTC_SYNC_EN
- Defined: 2-flop synchronisers on every irq_src bit and on nmi_src; latency as above.
- Undefined: sources are assumed synchronous to clk, with no synchronisers. Pending is set at E0 and irq_n goes low after E1.

Decomposition:
- Shared package intc_pkg:
  - register offsets (OFF_MASK=0, OFF_MODE=1, OFF_PEND=2, OFF_STAT=3);
  - FSM state encoding (2-bit);
  - ID_NMI=4'hE, ID_NONE=4'hF;
  - SPURIOUS_VEC=16'hFFFE.
- One sub-module: intc_priority_encoder. It is combinational: NUM_SRC-bit eligible in, {any, id[3:0]} out.

Test Plan:
- Reset, then read all four registers -> 8'h00, 8'h00, 8'h00, 8'h0F; irq_n=1, nmi_n=1.
- MASK=8'h0C, MODE=8'hFF, pulse irq_src[3] then irq_src[2], ack -> active_id=2, vector=16'hFFE4, PENDING=8'h08; after EOI, irq_n low again, ack -> id 3, vector=16'hFFE6.
- Level mode, MASK=8'h01, irq_src[0] held high, ack -> id 0 and PENDING bit 0 still 1; EOI -> REQ again; drop source -> PENDING=0, irq_n=1.
- Edge pending, clear MASK before ack, ack -> active_id=4'hF, vector=16'hFFFE, state IDLE.
- During SERVICE, nmi_src rising edge -> nmi_n=0; ack -> vector=16'hFFFA, active_id=4'hE; EOI then returns to IDLE.
- W1C write to PENDING coincident with a new edge on the same bit -> bit stays 1; rst pulse low mid-REQ -> irq_n=1 and all registers 0 the same cycle.
